// File: rtl/mac_ctrl_defs.sv
// ============================================================================
// Module : mac_ctrl_defs (package)
// Brief  : Shared state encoding and default widths for the MAC sequencer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mac_ctrl_defs;

  localparam int unsigned DEF_N  = 16;
  localparam int unsigned DEF_Q  = 12;
  localparam int unsigned DEF_CW = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACC   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_HOLD  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    ACC   = ST_ACC,
    DRAIN = ST_DRAIN,
    HOLD  = ST_HOLD
  } state_e;

endpackage

`default_nettype wire

// File: rtl/mac_seq_cnt.sv
// ============================================================================
// Module : mac_seq_cnt
// Brief  : Element counter with clear/increment and a terminal-count flag.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mac_seq_cnt
  import mac_ctrl_defs::*;
#(
  parameter int CW = DEF_CW
) (
  input  logic          clk,
  input  logic          sclr,
  input  logic          clr,
  input  logic          inc,
  input  logic [CW-1:0] len,
  output logic          tc
);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (sclr) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Only meaningful for len != 0; the controller never counts a zero-length run.
  assign tc = (count_q == (len - CW'(1)));

endmodule

`default_nettype wire

// File: rtl/mac_seq_ctrl.sv
// ============================================================================
// Module : mac_seq_ctrl
// Brief  : Sequences a shared MAC through a K-element dot product and returns
//          the accumulation on a valid/ready port. Optional macro RELU_EN
//          clamps negative results to zero.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mac_seq_ctrl
  import mac_ctrl_defs::*;
#(
  parameter int N  = DEF_N,
  parameter int Q  = DEF_Q,
  parameter int CW = DEF_CW
) (
  input  logic          clk,
  input  logic          sclr,
  input  logic          start,
  input  logic [CW-1:0] len,
  output logic          busy,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_a,
  input  logic [N-1:0]  in_b,
  output logic          mac_ce,
  output logic          mac_sclr,
  output logic [N-1:0]  mac_a,
  output logic [N-1:0]  mac_b,
  output logic [N-1:0]  mac_c,
  input  logic [N-1:0]  mac_p,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_data,
  output logic          done
);

  if (Q >= N) begin : g_q_check
    $error("mac_seq_ctrl: Q must be smaller than N");
  end

  state_e        state_q, state_d;
  logic [CW-1:0] len_q, len_d;
  logic          first_q, first_d;
  logic          out_valid_q, out_valid_d;
  logic [N-1:0]  out_data_q, out_data_d;
  logic          cnt_clr;
  logic          cnt_tc;
  logic          accept;
  logic          handshake;

  function automatic logic [N-1:0] relu_f(input logic [N-1:0] x);
`ifdef RELU_EN
    relu_f = x[N-1] ? '0 : x;
`else
    relu_f = x;
`endif
  endfunction

  assign busy      = (state_q != IDLE);
  assign in_ready  = (state_q == ACC);
  assign accept    = in_valid & in_ready;
  assign handshake = (state_q == HOLD) & out_valid_q & out_ready;
  assign done      = handshake;

  assign mac_sclr  = sclr;
  assign mac_ce    = accept;
  assign mac_a     = in_a;
  assign mac_b     = in_b;
  // First element starts a fresh sum, so stale p never leaks between runs.
  assign mac_c     = first_q ? '0 : mac_p;

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

  mac_seq_cnt #(
    .CW (CW)
  ) u_cnt (
    .clk  (clk),
    .sclr (sclr),
    .clr  (cnt_clr),
    .inc  (accept),
    .len  (len_q),
    .tc   (cnt_tc)
  );

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    first_d     = first_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    cnt_clr     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          len_d   = len;
          first_d = 1'b1;
          cnt_clr = 1'b1;
          if (len == '0) begin
            out_data_d  = '0;
            out_valid_d = 1'b1;
            state_d     = HOLD;
          end else begin
            state_d = ACC;
          end
        end
      end
      ACC: begin
        if (accept) begin
          first_d = 1'b0;
          if (cnt_tc) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        out_data_d  = relu_f(mac_p);
        out_valid_d = 1'b1;
        state_d     = HOLD;
      end
      HOLD: begin
        if (handshake) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (sclr) begin
      state_q     <= IDLE;
      len_q       <= '0;
      first_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      first_q     <= first_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

endmodule

`default_nettype wire
